// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared widths, reset PC and fetch entry type for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;
    localparam int              XLEN     = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two synchronous FIFO with flush, used for the in-flight
//            PC queue and the instruction buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_pop && !i_flush));
endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Credit-limited instruction fetch stage: owns the PC, tracks
//            in-flight fetches, buffers instructions and handles redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;

    logic            r_active;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_pcq_count;
    logic [CW-1:0]   w_buf_count;
    logic            w_pcq_empty;
    logic            w_pcq_full;
    logic            w_buf_empty;
    logic            w_buf_full;
    logic [XLEN-1:0] w_resp_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic [SW-1:0]   w_inflight;
    logic [CW-1:0]   w_drop_redirect;
    logic            w_req_fire;
    logic            w_resp_drop;
    logic            w_resp_take;
    logic            w_resp_any;
    logic            w_out_fire;
    fetch_entry_t    w_buf_in;
    fetch_entry_t    w_buf_head;

    assign w_inflight     = SW'(w_pcq_count) + SW'(w_buf_count) + SW'(r_drop);
    assign imem_req_valid = r_active && (w_inflight < SW'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_drop != '0);
    assign w_resp_take = imem_resp_valid && (r_drop == '0) && !w_pcq_empty;
    assign w_resp_any  = w_resp_drop || w_resp_take;

    // Everything still owed by memory becomes a drop, including a fetch accepted
    // this very cycle, minus any response that lands alongside the redirect.
    assign w_drop_redirect = CW'(SW'(r_drop) + SW'(w_pcq_count) + SW'(w_req_fire)
                                - SW'(w_resp_any));
    assign w_redirect_pc   = redirect_pc & ~XLEN'(3);

    assign w_buf_in.pc    = w_resp_pc;
    assign w_buf_in.instr = imem_resp_data;

    assign out_valid  = !w_buf_empty;
    assign w_out_fire = out_valid && out_ready;
    assign out_instr  = out_valid ? w_buf_head.instr : '0;
    assign out_pc     = out_valid ? w_buf_head.pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
            r_drop   <= '0;
        end else begin
            r_active <= 1'b1;
            if (redirect_valid) begin
                r_pc   <= w_redirect_pc;
                r_drop <= w_drop_redirect;
            end else begin
                if (w_req_fire)  r_pc   <= r_pc + XLEN'(4);
                if (w_resp_drop) r_drop <= r_drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_resp_take),
        .i_flush (redirect_valid),
        .o_data  (w_resp_pc),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_resp_take),
        .i_data  (w_buf_in),
        .i_pop   (w_out_fire),
        .i_flush (redirect_valid),
        .o_data  (w_buf_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_resp_take && w_buf_full && !w_out_fire && !redirect_valid));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_req_fire && w_pcq_full && !w_resp_take && !redirect_valid));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop <= CW'(DEPTH));
endmodule

`default_nettype wire
